decode_pipe_ctrl: RTL and testbench
===================================

DECODE_PIPE_CTRL -- requirements
Module: decode_pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 3, register-file address width.
REQ-002 SHALL have parameter DATA_W, default 8, immediate/offset width.
REQ-003 SHALL have parameter OPCODE_W, default 8, opcode field width (INSTRUCTION[31:32-OPCODE_W]).
REQ-004 SHALL have port CLK  input  1  single clock, rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous active-low reset.
REQ-006 SHALL have port INSTRUCTION  input  32  instruction word.
REQ-007 SHALL have port INSTR_VALID  input  1  INSTRUCTION is valid this cycle.
REQ-008 SHALL have port BUSYWAIT  input  1  data memory busy.
REQ-009 SHALL have ports INADDRESS, OUT1ADDRESS, OUT2ADDRESS  output  REG_ADDR_W  taken from fields [16+:W], [8+:W], [0+:W].
REQ-010 SHALL have ports IMMEDIATE_VAL, OFFSET  output  DATA_W  taken from [0+:DATA_W] and [16+:DATA_W].
REQ-011 SHALL have ports ALUOP  output  3, and CON_IMMEDIATE, CON_COMPLIMENT, CON_JUMP, CON_BEQ, WRITE, READ_MEM, WRITE_MEM, ALU_RDATA_SELECT  output  1 each.
REQ-012 SHALL have ports STALL  output  1  upstream must hold INSTRUCTION; and ILLEGAL  output  1  undecodable opcode.

Function
REQ-013 SHALL register all decode outputs: latency 1 cycle from the capturing CLK edge.
REQ-014 SHALL capture when INSTR_VALID=1 and STALL=0; otherwise SHALL issue a NOP (WRITE, READ_MEM, WRITE_MEM, CON_JUMP, CON_BEQ = 0; other outputs hold).
REQ-015 SHALL decode opcodes 0x00-0x0B: loadi, mov, add, sub, and, or, j, beq, lwd, lwi, swd, swi; ALUOP 000 forward, 001 add, 010 and, 011 or.
REQ-016 SHALL set CON_IMMEDIATE=0 for loadi/lwi/swi, CON_COMPLIMENT=1 for sub/beq, CON_JUMP=1 for j, CON_BEQ=1 for beq, ALU_RDATA_SELECT=1 for lwd/lwi; all else inactive.
REQ-017 SHALL implement FSM states RUN, MEM_WAIT, MEM_RELEASE.
REQ-018 RUN: on capturing a memory op, SHALL assert READ_MEM/WRITE_MEM and STALL and go to MEM_WAIT; WRITE SHALL stay 0 for loads.
REQ-019 MEM_WAIT: SHALL hold all outputs and STALL=1 while BUSYWAIT=1; on a cycle with BUSYWAIT=0 SHALL go to MEM_RELEASE.
REQ-020 MEM_RELEASE: SHALL drive READ_MEM=WRITE_MEM=0 for exactly one cycle, pulse WRITE=1 for loads only, keep STALL=1, then return to RUN.
REQ-021 SHALL guarantee at least one low cycle on READ_MEM/WRITE_MEM between back-to-back memory ops.
REQ-022 SHALL ignore BUSYWAIT while in RUN.
REQ-023 SHALL decode any unlisted opcode as NOP with ILLEGAL=1 for one cycle.
REQ-024 SHALL drive STALL combinationally from state: 1 in MEM_WAIT and MEM_RELEASE, and in RUN the cycle a memory op is issued.

Reset
REQ-025 SHALL, on RESET=0 at any time including mid-MEM_WAIT, enter RUN and clear all outputs to 0, except CON_IMMEDIATE=1.
REQ-026 SHALL resume capture on the first CLK edge after RESET deasserts.

Configuration
REQ-027 SHALL support macro DECODE_SHIFT_EN.
REQ-028 With DECODE_SHIFT_EN defined, SHALL decode 0x0C sll (ALUOP 100) and 0x0D srl (ALUOP 101), WRITE=1, CON_IMMEDIATE=0.
REQ-029 Without DECODE_SHIFT_EN, 0x0C/0x0D SHALL be illegal per REQ-023.

Structure
REQ-030 SHALL take opcode constants, ALUOP encodings and FSM state encoding from shared package cpu_ctrl_pkg.
REQ-031 SHALL place pure opcode-to-control mapping in sub-module decode_rom (combinational); decode_pipe_ctrl holds registers and FSM.

Verification
REQ-032 add 0x02030102 with INSTR_VALID=1 -> next cycle INADDRESS=3, OUT1ADDRESS=1, OUT2ADDRESS=2, ALUOP=001, WRITE=1, STALL=0.
REQ-033 lwi 0x09040023, BUSYWAIT high 3 cycles -> READ_MEM=1 for 4 cycles, STALL held, then one cycle READ_MEM=0, WRITE=1, ALU_RDATA_SELECT=1.
REQ-034 swd then lwd back-to-back -> WRITE_MEM falls for one cycle before READ_MEM rises; WRITE never 1 for swd.
REQ-035 RESET=0 during MEM_WAIT -> READ_MEM=0 immediately, STALL=0, FSM RUN.
REQ-036 opcode 0x0C -> with DECODE_SHIFT_EN ALUOP=100, WRITE=1; without, ILLEGAL=1, WRITE=0.
REQ-037 beq 0x07FC0102 -> CON_BEQ=1, CON_COMPLIMENT=1, OFFSET=0xFC, WRITE=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, ALU operation encodings, decode-pipe FSM states and
// the control-word struct used by decode_rom and decode_pipe_ctrl.
package cpu_ctrl_pkg;

  typedef logic [7:0] opcode_t;

  localparam opcode_t OP_LOADI = 8'h00;
  localparam opcode_t OP_MOV   = 8'h01;
  localparam opcode_t OP_ADD   = 8'h02;
  localparam opcode_t OP_SUB   = 8'h03;
  localparam opcode_t OP_AND   = 8'h04;
  localparam opcode_t OP_OR    = 8'h05;
  localparam opcode_t OP_J     = 8'h06;
  localparam opcode_t OP_BEQ   = 8'h07;
  localparam opcode_t OP_LWD   = 8'h08;
  localparam opcode_t OP_LWI   = 8'h09;
  localparam opcode_t OP_SWD   = 8'h0A;
  localparam opcode_t OP_SWI   = 8'h0B;
  localparam opcode_t OP_SLL   = 8'h0C;
  localparam opcode_t OP_SRL   = 8'h0D;

  typedef enum logic [2:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101
  } aluop_e;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_MEM_WAIT    = 2'd1,
    ST_MEM_RELEASE = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [2:0] aluop;
    logic       con_immediate;   // active low: 0 selects the immediate operand
    logic       con_compliment;
    logic       con_jump;
    logic       con_beq;
    logic       write;
    logic       read_mem;
    logic       write_mem;
    logic       alu_rdata_select;
    logic       illegal;
  } ctrl_t;

  // Quiescent control word: everything inactive, register operand selected.
  localparam ctrl_t CTRL_IDLE = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0};

  // A bubble: kill every side effect, keep operand/ALU selections as they were.
  function automatic ctrl_t ctrl_nop(input ctrl_t c);
    ctrl_t r;
    r           = c;
    r.write     = 1'b0;
    r.read_mem  = 1'b0;
    r.write_mem = 1'b0;
    r.con_jump  = 1'b0;
    r.con_beq   = 1'b0;
    r.illegal   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/decode_pipe_ctrl_if.sv
// Instruction/control bus between the fetch stage, the decode controller and
// the data memory.
interface decode_pipe_ctrl_if #(
  parameter int REG_ADDR_W = 3,
  parameter int DATA_W     = 8
);
  // Handshake: an instruction transfers on a rising CLK edge where
  // INSTR_VALID=1 and STALL=0; while STALL=1 the source holds INSTRUCTION.
  logic [31:0]           INSTRUCTION;
  logic                  INSTR_VALID;
  logic                  BUSYWAIT;
  logic [REG_ADDR_W-1:0] INADDRESS;
  logic [REG_ADDR_W-1:0] OUT1ADDRESS;
  logic [REG_ADDR_W-1:0] OUT2ADDRESS;
  logic [DATA_W-1:0]     IMMEDIATE_VAL;
  logic [DATA_W-1:0]     OFFSET;
  logic [2:0]            ALUOP;
  logic                  CON_IMMEDIATE;
  logic                  CON_COMPLIMENT;
  logic                  CON_JUMP;
  logic                  CON_BEQ;
  logic                  WRITE;
  logic                  READ_MEM;
  logic                  WRITE_MEM;
  logic                  ALU_RDATA_SELECT;
  logic                  STALL;
  logic                  ILLEGAL;

  modport master (
    output INSTRUCTION, INSTR_VALID, BUSYWAIT,
    input  INADDRESS, OUT1ADDRESS, OUT2ADDRESS, IMMEDIATE_VAL, OFFSET, ALUOP,
           CON_IMMEDIATE, CON_COMPLIMENT, CON_JUMP, CON_BEQ, WRITE, READ_MEM,
           WRITE_MEM, ALU_RDATA_SELECT, STALL, ILLEGAL
  );

  modport slave (
    input  INSTRUCTION, INSTR_VALID, BUSYWAIT,
    output INADDRESS, OUT1ADDRESS, OUT2ADDRESS, IMMEDIATE_VAL, OFFSET, ALUOP,
           CON_IMMEDIATE, CON_COMPLIMENT, CON_JUMP, CON_BEQ, WRITE, READ_MEM,
           WRITE_MEM, ALU_RDATA_SELECT, STALL, ILLEGAL
  );
endinterface

// File: rtl/decode_rom.sv
// Pure combinational opcode -> control-word table. Shift opcodes 0x0C/0x0D
// are decoded only when DECODE_SHIFT_EN is defined; otherwise they are illegal.
module decode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  logic [31:0] op_ext;
  assign op_ext = 32'(opcode);

  always_comb begin
    ctrl = CTRL_IDLE;
    case (op_ext)
      32'(OP_LOADI): begin ctrl.con_immediate = 1'b0; ctrl.write = 1'b1; end
      32'(OP_MOV):   ctrl.write = 1'b1;
      32'(OP_ADD):   begin ctrl.aluop = ALU_ADD; ctrl.write = 1'b1; end
      32'(OP_SUB):   begin
        ctrl.aluop = ALU_ADD; ctrl.con_compliment = 1'b1; ctrl.write = 1'b1;
      end
      32'(OP_AND):   begin ctrl.aluop = ALU_AND; ctrl.write = 1'b1; end
      32'(OP_OR):    begin ctrl.aluop = ALU_OR;  ctrl.write = 1'b1; end
      32'(OP_J):     ctrl.con_jump = 1'b1;
      // beq compares by subtracting, so it reuses the add path with complement.
      32'(OP_BEQ):   begin
        ctrl.aluop = ALU_ADD; ctrl.con_compliment = 1'b1; ctrl.con_beq = 1'b1;
      end
      32'(OP_LWD):   begin
        ctrl.read_mem = 1'b1; ctrl.alu_rdata_select = 1'b1; ctrl.write = 1'b1;
      end
      32'(OP_LWI):   begin
        ctrl.read_mem = 1'b1; ctrl.alu_rdata_select = 1'b1; ctrl.write = 1'b1;
        ctrl.con_immediate = 1'b0;
      end
      32'(OP_SWD):   ctrl.write_mem = 1'b1;
      32'(OP_SWI):   begin ctrl.write_mem = 1'b1; ctrl.con_immediate = 1'b0; end
`ifdef DECODE_SHIFT_EN
      32'(OP_SLL):   begin
        ctrl.aluop = ALU_SLL; ctrl.con_immediate = 1'b0; ctrl.write = 1'b1;
      end
      32'(OP_SRL):   begin
        ctrl.aluop = ALU_SRL; ctrl.con_immediate = 1'b0; ctrl.write = 1'b1;
      end
`endif
      default:       ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_pipe_ctrl.sv
// Registered instruction decode with a memory-access FSM (RUN/MEM_WAIT/
// MEM_RELEASE) that stalls fetch. Shift decode is enabled by DECODE_SHIFT_EN.
module decode_pipe_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int DATA_W     = 8,
  parameter int OPCODE_W   = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  decode_pipe_ctrl_if.slave  bus,
  output pipe_state_e        dbg_state
);

  pipe_state_e           state_q, state_d;
  ctrl_t                 ctrl_q, ctrl_d, rom_ctrl;
  logic [REG_ADDR_W-1:0] in_q, in_d, out1_q, out1_d, out2_q, out2_d;
  logic [DATA_W-1:0]     imm_q, imm_d, off_q, off_d;
  logic                  stall;
  logic                  capture;
  logic                  unused_instr;

  decode_rom #(.OPCODE_W(OPCODE_W)) u_rom (
    .opcode (bus.INSTRUCTION[31 -: OPCODE_W]),
    .ctrl   (rom_ctrl)
  );

  assign stall        = (state_q != ST_RUN);
  assign capture      = bus.INSTR_VALID && !stall;
  assign unused_instr = ^bus.INSTRUCTION;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    ctrl_d         = ctrl_q;
    ctrl_d.illegal = 1'b0;
    in_d           = in_q;
    out1_d         = out1_q;
    out2_d         = out2_q;
    imm_d          = imm_q;
    off_d          = off_q;
    case (state_q)
      ST_RUN: begin
        ctrl_d = ctrl_nop(ctrl_q);
        if (capture) begin
          if (rom_ctrl.illegal) begin
            ctrl_d.illegal = 1'b1;
          end else begin
            ctrl_d = rom_ctrl;
            in_d   = bus.INSTRUCTION[16 +: REG_ADDR_W];
            out1_d = bus.INSTRUCTION[8 +: REG_ADDR_W];
            out2_d = bus.INSTRUCTION[0 +: REG_ADDR_W];
            imm_d  = bus.INSTRUCTION[0 +: DATA_W];
            off_d  = bus.INSTRUCTION[16 +: DATA_W];
            // Load register write-back is deferred to the release cycle.
            if (rom_ctrl.read_mem || rom_ctrl.write_mem) begin
              ctrl_d.write = 1'b0;
              state_d      = ST_MEM_WAIT;
            end
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.BUSYWAIT) begin
          ctrl_d.write     = ctrl_q.read_mem;
          ctrl_d.read_mem  = 1'b0;
          ctrl_d.write_mem = 1'b0;
          state_d          = ST_MEM_RELEASE;
        end
      end
      ST_MEM_RELEASE: begin
        ctrl_d  = ctrl_nop(ctrl_q);
        state_d = ST_RUN;
      end
      default: begin
        ctrl_d  = ctrl_nop(ctrl_q);
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctrl_q <= CTRL_IDLE;
      in_q   <= '0;
      out1_q <= '0;
      out2_q <= '0;
      imm_q  <= '0;
      off_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      in_q   <= in_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
      imm_q  <= imm_d;
      off_q  <= off_d;
    end
  end

  assign bus.INADDRESS        = in_q;
  assign bus.OUT1ADDRESS      = out1_q;
  assign bus.OUT2ADDRESS      = out2_q;
  assign bus.IMMEDIATE_VAL    = imm_q;
  assign bus.OFFSET           = off_q;
  assign bus.ALUOP            = ctrl_q.aluop;
  assign bus.CON_IMMEDIATE    = ctrl_q.con_immediate;
  assign bus.CON_COMPLIMENT   = ctrl_q.con_compliment;
  assign bus.CON_JUMP         = ctrl_q.con_jump;
  assign bus.CON_BEQ          = ctrl_q.con_beq;
  assign bus.WRITE            = ctrl_q.write;
  assign bus.READ_MEM         = ctrl_q.read_mem;
  assign bus.WRITE_MEM        = ctrl_q.write_mem;
  assign bus.ALU_RDATA_SELECT = ctrl_q.alu_rdata_select;
  assign bus.ILLEGAL          = ctrl_q.illegal;
  assign bus.STALL            = stall;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Bench for decode_pipe_ctrl: transaction-level expected-output model, per-cycle
// scoreboard, directed cases and randomized instruction streams.
module tb_decode_pipe_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int RW = 3;
  localparam int DW = 8;

  typedef struct packed {
    logic [RW-1:0] inaddr;
    logic [RW-1:0] out1;
    logic [RW-1:0] out2;
    logic [DW-1:0] imm;
    logic [DW-1:0] off;
    logic [2:0]    aluop;
    logic con_imm, con_comp, con_jump, con_beq, write, rd, wm, rsel, stall, illegal;
  } out_t;

  localparam int W = $bits(out_t);

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  pipe_state_e dbg_state;

  always #5 clk = ~clk;

  decode_pipe_ctrl_if #(.REG_ADDR_W(RW), .DATA_W(DW)) bus ();

  decode_pipe_ctrl #(.REG_ADDR_W(RW), .DATA_W(DW), .OPCODE_W(8)) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] chk_exp;
  out_t         exp_cur;
  out_t         rst_vec;
  bit           chk_en = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic out_t pack_actual();
    out_t a;
    a.inaddr   = bus.INADDRESS;
    a.out1     = bus.OUT1ADDRESS;
    a.out2     = bus.OUT2ADDRESS;
    a.imm      = bus.IMMEDIATE_VAL;
    a.off      = bus.OFFSET;
    a.aluop    = bus.ALUOP;
    a.con_imm  = bus.CON_IMMEDIATE;
    a.con_comp = bus.CON_COMPLIMENT;
    a.con_jump = bus.CON_JUMP;
    a.con_beq  = bus.CON_BEQ;
    a.write    = bus.WRITE;
    a.rd       = bus.READ_MEM;
    a.wm       = bus.WRITE_MEM;
    a.rsel     = bus.ALU_RDATA_SELECT;
    a.stall    = bus.STALL;
    a.illegal  = bus.ILLEGAL;
    return a;
  endfunction

  // ---------------- reference model ----------------
  function automatic out_t m_nop(input out_t p);
    out_t r = p;
    r.write = 1'b0; r.rd = 1'b0; r.wm = 1'b0; r.con_jump = 1'b0; r.con_beq = 1'b0;
    r.illegal = 1'b0; r.stall = 1'b0;
    return r;
  endfunction

  function automatic out_t m_capture(input out_t p, input logic [31:0] ins);
    out_t       r  = m_nop(p);
    logic [7:0] op = ins[31:24];
    logic [2:0] alu = 3'd0;
    bit ok = 1, ci = 1, cc = 0, cj = 0, cb = 0, w = 0, rd = 0, wm = 0, rs = 0;
    case (op)
      8'h00: begin ci = 0; w = 1; end
      8'h01: w = 1;
      8'h02: begin alu = 3'd1; w = 1; end
      8'h03: begin alu = 3'd1; cc = 1; w = 1; end
      8'h04: begin alu = 3'd2; w = 1; end
      8'h05: begin alu = 3'd3; w = 1; end
      8'h06: cj = 1;
      8'h07: begin alu = 3'd1; cc = 1; cb = 1; end
      8'h08: begin rd = 1; rs = 1; end
      8'h09: begin rd = 1; rs = 1; ci = 0; end
      8'h0A: wm = 1;
      8'h0B: begin wm = 1; ci = 0; end
`ifdef DECODE_SHIFT_EN
      8'h0C: begin alu = 3'd4; ci = 0; w = 1; end
      8'h0D: begin alu = 3'd5; ci = 0; w = 1; end
`endif
      default: ok = 0;
    endcase
    if (!ok) begin
      r.illegal = 1'b1;
      return r;
    end
    r.inaddr = ins[16 +: RW];
    r.out1   = ins[8 +: RW];
    r.out2   = ins[0 +: RW];
    r.imm    = ins[0 +: DW];
    r.off    = ins[16 +: DW];
    r.aluop  = alu;
    r.con_imm = ci; r.con_comp = cc; r.con_jump = cj; r.con_beq = cb;
    r.write = w; r.rd = rd; r.wm = wm; r.rsel = rs;
    r.stall = rd | wm;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick_push();
    @(posedge clk);
    if (chk_en) exp_q.push_back(exp_cur);
    #1;
  endtask

  task automatic do_instr(input logic [31:0] ins, input bit valid, input int busy);
    bit load;
    bus.INSTRUCTION = ins;
    bus.INSTR_VALID = valid;
    bus.BUSYWAIT    = 1'($urandom_range(0, 1));
    if (!valid) begin
      exp_cur = m_nop(exp_cur);
      tick_push();
      return;
    end
    exp_cur = m_capture(exp_cur, ins);
    tick_push();
    if (exp_cur.rd || exp_cur.wm) begin
      load = exp_cur.rd;
      for (int b = 0; b < busy; b++) begin
        bus.BUSYWAIT    = 1'b1;
        bus.INSTRUCTION = $urandom();
        bus.INSTR_VALID = 1'($urandom_range(0, 1));
        tick_push();
      end
      bus.BUSYWAIT = 1'b0;
      exp_cur.rd = 1'b0; exp_cur.wm = 1'b0; exp_cur.write = load;
      tick_push();
      bus.INSTRUCTION = $urandom();
      bus.INSTR_VALID = 1'($urandom_range(0, 1));
      exp_cur = m_nop(exp_cur);
      tick_push();
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && exp_q.size() > 0) begin
      chk_exp = exp_q.pop_front();
      chk($sformatf("cycle@%0t", $time), 64'(pack_actual()), 64'(chk_exp));
    end
  end

  // Memory-strobe monitor: READ_MEM run length, release-cycle outputs, gap.
  logic mem_act;
  int   rd_run = 0, last_rd_run = 0, low_cnt = 0, last_gap = -1;
  bit   last_fall_write = 1'b0, last_fall_rsel = 1'b0, prev_mem = 1'b0, seen_mem = 1'b0;
  assign mem_act = bus.READ_MEM | bus.WRITE_MEM;

  always @(negedge clk) begin
    if (bus.READ_MEM) rd_run <= rd_run + 1;
    else if (rd_run > 0) begin
      last_rd_run     <= rd_run;
      last_fall_write <= bus.WRITE;
      last_fall_rsel  <= bus.ALU_RDATA_SELECT;
      rd_run          <= 0;
    end
    if (mem_act && !prev_mem) begin
      if (seen_mem) last_gap <= low_cnt;
      seen_mem <= 1'b1;
      low_cnt  <= 0;
    end else if (!mem_act) low_cnt <= low_cnt + 1;
    prev_mem <= mem_act;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_vec = '0;
    rst_vec.con_imm = 1'b1;
    exp_cur = rst_vec;
    bus.INSTRUCTION = 32'h0;
    bus.INSTR_VALID = 1'b0;
    bus.BUSYWAIT    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_con_imm", 64'(bus.CON_IMMEDIATE), 64'd1);
    chk("rst_write",   64'(bus.WRITE), 64'd0);
    chk("rst_stall",   64'(bus.STALL), 64'd0);
    chk("rst_state",   64'(dbg_state), 64'(ST_RUN));
    chk("rst_all",     64'(pack_actual()), 64'(rst_vec));
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // add r3 = r1 + r2
    do_instr(32'h02030102, 1'b1, 0);
    chk("add_inaddr", 64'(bus.INADDRESS), 64'd3);
    chk("add_out1",   64'(bus.OUT1ADDRESS), 64'd1);
    chk("add_out2",   64'(bus.OUT2ADDRESS), 64'd2);
    chk("add_aluop",  64'(bus.ALUOP), 64'd1);
    chk("add_write",  64'(bus.WRITE), 64'd1);
    chk("add_stall",  64'(bus.STALL), 64'd0);

    // lwi with three busy cycles
    do_instr(32'h09040023, 1'b1, 3);
    chk("lwi_rd_cycles",  64'(last_rd_run), 64'd4);
    chk("lwi_rel_write",  64'(last_fall_write), 64'd1);
    chk("lwi_rel_rdsel",  64'(last_fall_rsel), 64'd1);

    // swd immediately followed by lwd
    do_instr(32'h0A000102, 1'b1, 1);
    do_instr(32'h08010203, 1'b1, 2);
    chk("swd_lwd_gap_ge1", 64'(last_gap >= 1), 64'd1);

    // beq with negative offset
    do_instr(32'h07FC0102, 1'b1, 0);
    chk("beq_con_beq", 64'(bus.CON_BEQ), 64'd1);
    chk("beq_comp",    64'(bus.CON_COMPLIMENT), 64'd1);
    chk("beq_offset",  64'(bus.OFFSET), 64'hFC);
    chk("beq_write",   64'(bus.WRITE), 64'd0);

    // opcode 0x0C
    do_instr(32'h0C010203, 1'b1, 0);
`ifdef DECODE_SHIFT_EN
    chk("sll_aluop",   64'(bus.ALUOP), 64'd4);
    chk("sll_write",   64'(bus.WRITE), 64'd1);
    chk("sll_illegal", 64'(bus.ILLEGAL), 64'd0);
`else
    chk("op0c_illegal", 64'(bus.ILLEGAL), 64'd1);
    chk("op0c_write",   64'(bus.WRITE), 64'd0);
`endif
    do_instr(32'h0, 1'b0, 0);
    chk("illegal_one_cycle", 64'(bus.ILLEGAL), 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom();
      ins[31:24] = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ins[31:24] = 8'($urandom_range(16, 255));
      do_instr(ins, $urandom_range(0, 4) != 0, $urandom_range(0, 4));
    end

    // Reset in the middle of a load's wait phase
    bus.INSTRUCTION = 32'h08050006;
    bus.INSTR_VALID = 1'b1;
    bus.BUSYWAIT    = 1'b0;
    exp_cur = m_capture(exp_cur, 32'h08050006);
    tick_push();
    bus.BUSYWAIT = 1'b1;
    tick_push();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_read_mem", 64'(bus.READ_MEM), 64'd0);
    chk("midrst_stall",    64'(bus.STALL), 64'd0);
    chk("midrst_state",    64'(dbg_state), 64'(ST_RUN));
    chk("midrst_con_imm",  64'(bus.CON_IMMEDIATE), 64'd1);
    chk("midrst_inaddr",   64'(bus.INADDRESS), 64'd0);
    bus.INSTR_VALID = 1'b0;
    bus.BUSYWAIT    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_cur = rst_vec;
    chk_en  = 1'b1;

    // First edge after reset release must capture
    do_instr(32'h05020301, 1'b1, 0);
    chk("resume_inaddr", 64'(bus.INADDRESS), 64'd2);
    chk("resume_aluop",  64'(bus.ALUOP), 64'd3);

    for (int i = 0; i < 100; i++) begin
      logic [31:0] ins;
      ins = $urandom();
      ins[31:24] = 8'($urandom_range(0, 15));
      do_instr(ins, $urandom_range(0, 3) != 0, $urandom_range(0, 3));
    end

    do_instr(32'h0, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
